// File: rtl/sc_sync_ctrl.sv
// rtl/sc_sync_ctrl.sv - Schmidl-Cox sync sequencer; optional stats counters under SC_SYNC_CTRL_STATS_EN
module sc_sync_ctrl #(
  parameter int BASE       = 0,
  parameter int CLR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [15:0] trig_i_tdata,
  input  logic        trig_i_tvalid,
  output logic        trig_i_tready,
  output logic [15:0] trig_o_tdata,
  output logic        trig_o_tvalid,
  input  logic        trig_o_tready,
  input  logic        smp_stb,
  output logic        dp_clear,
  output logic        eof,
  output logic [15:0] cfo_phase,
  output logic [2:0]  state,
  output logic [31:0] rb_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SEARCH  = 3'd2,
    S_FRAME   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  localparam logic [7:0]  A_CTRL  = 8'(BASE);
  localparam logic [7:0]  A_FLEN  = 8'(BASE + 1);
  localparam logic [7:0]  A_HOLD  = 8'(BASE + 2);
  localparam logic [7:0]  A_TMO   = 8'(BASE + 3);
  localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);

  state_t      st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cfo_q, cfo_d;
  logic        enable_q, soft_clr_q;
  logic [15:0] frame_len_q, holdoff_len_q, trig_timeout_q;
  logic        wr_ctrl, wr_flen, wr_hold, wr_tmo;
  logic [15:0] frame_last, cnt_inc;
  logic        override, eof_c, itr_c, otv_c;

  assign wr_ctrl = set_stb && (set_addr == A_CTRL);
  assign wr_flen = set_stb && (set_addr == A_FLEN);
  assign wr_hold = set_stb && (set_addr == A_HOLD);
  assign wr_tmo  = set_stb && (set_addr == A_TMO);

`ifdef SC_SYNC_CTRL_STATS_EN
  logic        rb_sel_q;
  logic [15:0] frames_done_q, trig_dropped_q;
  logic        unused_bits;
  assign unused_bits = ^set_data[31:16];
`else
  logic        unused_bits;
  assign unused_bits = ^{set_data[31:16], set_data[2]};
`endif

  // Settings registers; soft_clear is a one-cycle pulse acted on the cycle after the write
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      enable_q       <= 1'b0;
      soft_clr_q     <= 1'b0;
      frame_len_q    <= 16'd80;
      holdoff_len_q  <= 16'd0;
      trig_timeout_q <= 16'd0;
`ifdef SC_SYNC_CTRL_STATS_EN
      rb_sel_q       <= 1'b0;
`endif
    end else begin
      soft_clr_q <= wr_ctrl && set_data[1];
      if (wr_ctrl) begin
        enable_q <= set_data[0];
`ifdef SC_SYNC_CTRL_STATS_EN
        rb_sel_q <= set_data[2];
`endif
      end
      if (wr_flen) frame_len_q    <= set_data[15:0];
      if (wr_hold) holdoff_len_q  <= set_data[15:0];
      if (wr_tmo)  trig_timeout_q <= set_data[15:0];
    end
  end

  // A zero frame length behaves as a one-sample frame
  assign frame_last = (frame_len_q == 16'd0) ? 16'd0 : frame_len_q - 16'd1;
  assign cnt_inc    = cnt_q + 16'd1;
  assign override   = !enable_q || (soft_clr_q && (st_q != S_IDLE));

  // Next-state, counter and stream-gating logic; disable beats soft clear beats events
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    cfo_d = cfo_q;
    eof_c = 1'b0;
    itr_c = 1'b0;
    otv_c = 1'b0;
    case (st_q)
      S_SEARCH: begin
        otv_c = trig_i_tvalid && !override;
        itr_c = trig_o_tready && !override;
      end
      S_FRAME, S_HOLDOFF: itr_c = 1'b1;
      default: ;
    endcase
    if (!enable_q) begin
      st_d  = S_IDLE;
      cnt_d = 16'd0;
    end else if (soft_clr_q && (st_q != S_IDLE)) begin
      st_d  = S_CLEAR;
      cnt_d = 16'd0;
    end else begin
      case (st_q)
        S_IDLE: begin
          st_d  = S_CLEAR;
          cnt_d = 16'd0;
        end
        S_CLEAR: begin
          if (cnt_q == CLR_LAST) begin
            st_d  = S_SEARCH;
            cnt_d = 16'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_SEARCH: begin
          if (trig_i_tvalid && trig_o_tready) begin
            cfo_d = trig_i_tdata;
            cnt_d = 16'd0;
            st_d  = S_FRAME;
          end else if (smp_stb) begin
            if ((trig_timeout_q != 16'd0) && (cnt_inc == trig_timeout_q)) begin
              st_d  = S_CLEAR;
              cnt_d = 16'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_FRAME: begin
          if (smp_stb) begin
            if (cnt_q == frame_last) begin
              eof_c = 1'b1;
              cnt_d = 16'd0;
              st_d  = (holdoff_len_q == 16'd0) ? S_CLEAR : S_HOLDOFF;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_HOLDOFF: begin
          if (smp_stb) begin
            if (cnt_inc == holdoff_len_q) begin
              st_d  = S_CLEAR;
              cnt_d = 16'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          st_d  = S_IDLE;
          cnt_d = 16'd0;
        end
      endcase
    end
  end

  // State, shared counter and CFO phase registers
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      st_q  <= S_IDLE;
      cnt_q <= 16'd0;
      cfo_q <= 16'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      cfo_q <= cfo_d;
    end
  end

`ifdef SC_SYNC_CTRL_STATS_EN
  // Saturating frame and dropped-trigger counters
  always_ff @(posedge clk) begin
    if (!aresetn || soft_clr_q) begin
      frames_done_q  <= 16'd0;
      trig_dropped_q <= 16'd0;
    end else begin
      if (eof_c && (frames_done_q != 16'hffff)) frames_done_q <= frames_done_q + 16'd1;
      if (((st_q == S_FRAME) || (st_q == S_HOLDOFF)) && trig_i_tvalid && itr_c &&
          (trig_dropped_q != 16'hffff))
        trig_dropped_q <= trig_dropped_q + 16'd1;
    end
  end
  assign rb_data = rb_sel_q ? {frames_done_q, trig_dropped_q} : {13'b0, st_q, cnt_q};
`else
  assign rb_data = {13'b0, st_q, cnt_q};
`endif

  assign trig_o_tdata  = trig_i_tdata;
  assign trig_o_tvalid = otv_c;
  assign trig_i_tready = itr_c;
  assign eof           = eof_c;
  assign dp_clear      = (st_q == S_IDLE) || (st_q == S_CLEAR);
  assign cfo_phase     = cfo_q;
  assign state         = st_q;

endmodule

// File: tb/tb_sc_sync_ctrl.sv
// tb/tb_sc_sync_ctrl.sv - self-checking bench for sc_sync_ctrl
module tb_sc_sync_ctrl;

  localparam int CLR = 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [15:0] trig_i_tdata;
  logic        trig_i_tvalid;
  logic        trig_i_tready;
  logic [15:0] trig_o_tdata;
  logic        trig_o_tvalid;
  logic        trig_o_tready;
  logic        smp_stb;
  logic        dp_clear;
  logic        eof;
  logic [15:0] cfo_phase;
  logic [2:0]  state;
  logic [31:0] rb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_sync_ctrl #(.BASE(0), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .aresetn(aresetn),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .trig_i_tdata(trig_i_tdata), .trig_i_tvalid(trig_i_tvalid), .trig_i_tready(trig_i_tready),
    .trig_o_tdata(trig_o_tdata), .trig_o_tvalid(trig_o_tvalid), .trig_o_tready(trig_o_tready),
    .smp_stb(smp_stb), .dp_clear(dp_clear), .eof(eof), .cfo_phase(cfo_phase),
    .state(state), .rb_data(rb_data)
  );

  typedef struct {
    logic        tv;
    logic [15:0] td;
    logic        ordy;
    logic        smp;
    logic [2:0]  e_st;
    logic [15:0] e_cnt;
    logic        ck_cnt;
    logic        e_eof;
    logic        e_itr;
    logic        e_otv;
    logic        e_dp;
    logic [15:0] e_cfo;
  } vec_t;

  vec_t tbl[14];

  // reference model state
  int          m_st, m_cnt, m_clr_left, m_en, m_soft, m_flen, m_hold, m_tmo;
  logic [15:0] m_cfo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int k = 0;
    while (state != s && k < 40) begin
      tick();
      k++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_clr_left = 0; m_cfo = 16'h0;
    m_en = 0; m_soft = 0; m_flen = 80; m_hold = 0; m_tmo = 0;
  endtask

  // Checks current outputs against the model, then advances the model across the coming edge
  task automatic model_cycle();
    bit ovr, e_otv, e_itr, e_eof, hs;
    int flen;
    ovr   = (m_en == 0) || (m_soft != 0 && m_st != 0);
    flen  = (m_flen == 0) ? 1 : m_flen;
    e_otv = (m_st == 2) && !ovr && trig_i_tvalid;
    e_itr = (m_st == 2) ? (!ovr && trig_o_tready) : (m_st == 3 || m_st == 4);
    e_eof = !ovr && m_st == 3 && smp_stb && (m_cnt + 1 == flen);
    chk("rnd_state", 32'(state), 32'(m_st));
    chk("rnd_dp_clear", 32'(dp_clear), 32'(m_st <= 1));
    chk("rnd_o_tvalid", 32'(trig_o_tvalid), 32'(e_otv));
    chk("rnd_i_tready", 32'(trig_i_tready), 32'(e_itr));
    chk("rnd_eof", 32'(eof), 32'(e_eof));
    chk("rnd_cfo", 32'(cfo_phase), 32'(m_cfo));
    if (m_st != 1) chk("rnd_cnt", rb_data, 32'(m_st) << 16 | 32'(m_cnt));
    if (m_st == 2) chk("rnd_o_tdata", 32'(trig_o_tdata), 32'(trig_i_tdata));
    if (!aresetn) begin
      model_reset();
      return;
    end
    hs = trig_i_tvalid && trig_o_tready;
    if (m_en == 0) begin
      m_st = 0; m_cnt = 0;
    end else if (m_soft != 0 && m_st != 0) begin
      m_st = 1; m_cnt = 0; m_clr_left = CLR;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_clr_left = CLR; end
        1: begin
          m_clr_left--;
          if (m_clr_left == 0) begin m_st = 2; m_cnt = 0; end
        end
        2: begin
          if (hs) begin
            m_cfo = trig_i_tdata; m_st = 3; m_cnt = 0;
          end else if (smp_stb) begin
            m_cnt++;
            if (m_tmo != 0 && m_cnt == m_tmo) begin m_st = 1; m_cnt = 0; m_clr_left = CLR; end
          end
        end
        3: if (smp_stb) begin
          if (m_cnt + 1 == flen) begin
            m_cnt = 0;
            if (m_hold == 0) begin m_st = 1; m_clr_left = CLR; end
            else m_st = 4;
          end else m_cnt++;
        end
        4: if (smp_stb) begin
          m_cnt++;
          if (m_cnt == m_hold) begin m_st = 1; m_cnt = 0; m_clr_left = CLR; end
        end
        default: ;
      endcase
    end
    m_soft = (set_stb && set_addr == 8'd0 && set_data[1]) ? 1 : 0;
    if (set_stb && set_addr == 8'd0) m_en = int'(set_data[0]);
    if (set_stb && set_addr == 8'd1) m_flen = int'(set_data[15:0]);
    if (set_stb && set_addr == 8'd2) m_hold = int'(set_data[15:0]);
    if (set_stb && set_addr == 8'd3) m_tmo = int'(set_data[15:0]);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, eof_at, bad;
    // frame_len=3, holdoff=2, starting in SEARCH with cnt 0 and no prior trigger
    tbl[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 3'd2, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 16'h5555, 1'b1, 1'b1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[4]  = '{1'b1, 16'h0777, 1'b0, 1'b1, 3'd3, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[6]  = '{1'b1, 16'h9999, 1'b1, 1'b1, 3'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[9]  = '{1'b1, 16'h4321, 1'b1, 1'b1, 3'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[10] = '{1'b1, 16'h4321, 1'b1, 1'b1, 3'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};

    aresetn = 1'b0; set_stb = 1'b0; set_addr = 8'h0; set_data = 32'h0;
    trig_i_tdata = 16'h0; trig_i_tvalid = 1'b0; trig_o_tready = 1'b0; smp_stb = 1'b0;
    tick(); tick();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_dp_clear", 32'(dp_clear), 32'd1);
    chk("reset_eof", 32'(eof), 32'd0);
    chk("reset_cfo", 32'(cfo_phase), 32'd0);
    chk("reset_rb", rb_data, 32'd0);
    chk("reset_o_tvalid", 32'(trig_o_tvalid), 32'd0);
    aresetn = 1'b1;
    tick();

    // enable: CLEAR lasts CLR cycles then SEARCH
    wr(8'd1, 32'd3);
    wr(8'd2, 32'd2);
    wr(8'd0, 32'd1);
    chk("idle_before_clear", 32'(state), 32'd0);
    tick();
    k = 0;
    while (state == 3'd1 && dp_clear && k < 20) begin
      tick();
      k++;
    end
    chk("clear_len", 32'(k), 32'(CLR));
    chk("search_state", 32'(state), 32'd2);
    chk("search_dp_clear", 32'(dp_clear), 32'd0);

    // table-driven frame walk
    for (int i = 0; i < 14; i++) begin
      trig_i_tvalid = tbl[i].tv; trig_i_tdata = tbl[i].td;
      trig_o_tready = tbl[i].ordy; smp_stb = tbl[i].smp;
      #1;
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_st));
      if (tbl[i].ck_cnt) chk($sformatf("tbl%0d_cnt", i), 32'(rb_data[15:0]), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_eof", i), 32'(eof), 32'(tbl[i].e_eof));
      chk($sformatf("tbl%0d_i_tready", i), 32'(trig_i_tready), 32'(tbl[i].e_itr));
      chk($sformatf("tbl%0d_o_tvalid", i), 32'(trig_o_tvalid), 32'(tbl[i].e_otv));
      chk($sformatf("tbl%0d_dp_clear", i), 32'(dp_clear), 32'(tbl[i].e_dp));
      chk($sformatf("tbl%0d_cfo", i), 32'(cfo_phase), 32'(tbl[i].e_cfo));
      tick();
    end
    smp_stb = 1'b0; trig_i_tvalid = 1'b0; trig_o_tready = 1'b0;

    // frame_len 80, holdoff 16, continuous triggers during the frame
    wr(8'd1, 32'd80);
    wr(8'd2, 32'd16);
    trig_i_tvalid = 1'b1; trig_i_tdata = 16'h1234; trig_o_tready = 1'b1;
    tick();
    chk("f80_state", 32'(state), 32'd3);
    chk("f80_cfo", 32'(cfo_phase), 32'h1234);
    k = 0; eof_at = 0; bad = 0;
    while (state == 3'd3 && k < 200) begin
      smp_stb = 1'b1; trig_i_tdata = 16'($urandom);
      #1;
      k++;
      if (eof) eof_at = k;
      if (trig_o_tvalid || !trig_i_tready) bad++;
      tick();
    end
    chk("f80_eof_at", 32'(eof_at), 32'd80);
    chk("f80_drop_gating", 32'(bad), 32'd0);
    chk("f80_holdoff", 32'(state), 32'd4);
    chk("f80_cfo_kept", 32'(cfo_phase), 32'h1234);
    trig_i_tvalid = 1'b0;
    k = 0;
    while (state == 3'd4 && k < 100) begin
      smp_stb = 1'b1;
      #1;
      k++;
      tick();
    end
    chk("holdoff_len", 32'(k), 32'd16);
    chk("holdoff_to_clear", 32'(state), 32'd1);
    smp_stb = 1'b0;

    // trigger timeout: resync after 5 samples; handshake on the 5th wins
    wait_state(3'd2, "tmo_search");
    wr(8'd3, 32'd5);
    k = 0;
    while (state == 3'd2 && k < 50) begin
      smp_stb = 1'b1;
      #1;
      k++;
      tick();
    end
    chk("tmo_count", 32'(k), 32'd5);
    chk("tmo_clear", 32'(state), 32'd1);
    smp_stb = 1'b0;
    wait_state(3'd2, "tmo_search2");
    for (int i = 1; i <= 5; i++) begin
      smp_stb = 1'b1; trig_i_tvalid = (i == 5); trig_i_tdata = 16'hbeef; trig_o_tready = 1'b1;
      tick();
    end
    chk("tmo_hs_wins", 32'(state), 32'd3);
    chk("tmo_hs_cfo", 32'(cfo_phase), 32'hbeef);
    trig_i_tvalid = 1'b0;

    // enable dropped mid-frame
    tick(); tick();
    wr(8'd0, 32'd0);
    tick();
    #1;
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_dp_clear", 32'(dp_clear), 32'd1);
    chk("dis_eof", 32'(eof), 32'd0);
    chk("dis_cnt", 32'(rb_data[15:0]), 32'd0);

    // reset asserted mid-holdoff
    smp_stb = 1'b0;
    wr(8'd3, 32'd0);
    wr(8'd1, 32'd2);
    wr(8'd2, 32'd50);
    wr(8'd0, 32'd1);
    wait_state(3'd2, "rst_search");
    trig_i_tvalid = 1'b1; trig_o_tready = 1'b1; trig_i_tdata = 16'h0abc;
    tick();
    trig_i_tvalid = 1'b0; smp_stb = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_pre_holdoff", 32'(state), 32'd4);
    aresetn = 1'b0;
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_dp_clear", 32'(dp_clear), 32'd1);
    chk("rst_eof", 32'(eof), 32'd0);
    chk("rst_rb", rb_data, 32'd0);
    chk("rst_cfo", 32'(cfo_phase), 32'd0);

    // randomized run against the reference model
    smp_stb = 1'b0; trig_o_tready = 1'b0;
    tick();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      aresetn = ($urandom_range(0, 399) != 0);
      trig_i_tvalid = ($urandom_range(0, 3) == 0);
      trig_i_tdata = 16'($urandom);
      trig_o_tready = ($urandom_range(0, 3) != 0);
      smp_stb = ($urandom_range(0, 2) != 0);
      set_stb = (n < 2) || ($urandom_range(0, 24) == 0);
      set_addr = (n < 2) ? 8'd0 : 8'($urandom_range(0, 4));
      case (set_addr)
        8'd0: set_data = {30'd0, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) != 0 || n < 2)};
        8'd1: set_data = 32'($urandom_range(0, 6));
        8'd2: set_data = 32'($urandom_range(0, 4));
        8'd3: set_data = 32'($urandom_range(0, 9));
        default: set_data = $urandom;
      endcase
      #1;
      model_cycle();
      tick();
    end
    set_stb = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
